// File: rtl/decode_stage_hz.sv
// decode_stage_hz: register file read, load-use hazard detection and the
// decode->EX pipeline register.
//
// Ports:
//   clk, rst                  rising-edge clock; async active-high reset
//   valid_d, instr_d          decode instruction (rs1=[19:15] rs2=[24:20] rd=[11:7])
//   pc_d, pc_plus4_d, imm_d   decode operands
//   ctrl_d, mem_read_d        decoded control bundle, load flag
//   flush_e                   squash the decode instruction (taken branch in EX)
//   reg_write_w, rd_w, result_w  writeback port
//   stall_fd                  hold fetch/decode (combinational)
//   valid_e ... ctrl_e        EX-stage register outputs
//   stall_cnt                 saturating count of load-use stalls
module decode_stage_hz #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              mem_read_d,
  input  logic              flush_e,
  input  logic              reg_write_w,
  input  logic [4:0]        rd_w,
  input  logic [XLEN-1:0]   result_w,
  output logic              stall_fd,
  output logic              valid_e,
  output logic              mem_read_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int IDX_W = $clog2(NREG);

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  logic [XLEN-1:0]  rf_q [NREG];
  logic [XLEN-1:0]  rf_d [NREG];
  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]       rs1_d, rs2_d, rdi_d;
  logic [XLEN-1:0]  rd1_d, rd2_d;
  logic             hz;

  // Opcode/funct fields are decoded upstream; only register indices matter here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};

  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];
  assign rdi_d = instr_d[11:7];

  // Index 0 and indices beyond the implemented file are hardwired zero.
  function automatic logic legal_idx(input logic [4:0] idx);
    return (idx != 5'd0) && ({27'd0, idx} < 32'(NREG));
  endfunction

  always_comb begin
    rf_d = rf_q;
    if (reg_write_w && legal_idx(rd_w)) rf_d[rd_w[IDX_W-1:0]] = result_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Write-through read: a same-cycle writeback is visible to decode, so the
  // EX register captures the fresh value without a separate bypass stage.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (legal_idx(rs1_d))
      rd1_d = (reg_write_w && rd_w == rs1_d) ? result_w : rf_q[rs1_d[IDX_W-1:0]];
    if (legal_idx(rs2_d))
      rd2_d = (reg_write_w && rd_w == rs2_d) ? result_w : rf_q[rs2_d[IDX_W-1:0]];
  end

  assign hz = valid_d & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
              ((ex_q.rd == rs1_d) | (ex_q.rd == rs2_d));

  // A flush kills the dependent instruction anyway, so no stall is needed.
  assign stall_fd = hz & ~flush_e;

  always_comb begin
    ex_d = '0;
    if (!flush_e && !hz && valid_d) begin
      ex_d.valid    = 1'b1;
      ex_d.mem_read = mem_read_d;
      ex_d.rd1      = rd1_d;
      ex_d.rd2      = rd2_d;
      ex_d.imm      = imm_d;
      ex_d.pc       = pc_d;
      ex_d.pc_plus4 = pc_plus4_d;
      ex_d.rs1      = rs1_d;
      ex_d.rs2      = rs2_d;
      ex_d.rd       = rdi_d;
      ex_d.ctrl     = ctrl_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fd && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_e    = ex_q.valid;
  assign mem_read_e = ex_q.mem_read;
  assign rd1_e      = ex_q.rd1;
  assign rd2_e      = ex_q.rd2;
  assign imm_e      = ex_q.imm;
  assign pc_e       = ex_q.pc;
  assign pc_plus4_e = ex_q.pc_plus4;
  assign rs1_e      = ex_q.rs1;
  assign rs2_e      = ex_q.rs2;
  assign rd_e       = ex_q.rd;
  assign ctrl_e     = ex_q.ctrl;
  assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz. u_dut uses default parameters; u_dut2
// (NREG=16, CNT_W=2) shares every input and is checked where its parameters
// make a difference.
module tb_decode_stage_hz;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d, mem_read_d, flush_e, reg_write_w;
  logic [31:0] instr_d, pc_d, pc_plus4_d, imm_d, result_w;
  logic [11:0] ctrl_d;
  logic [4:0]  rd_w;

  logic        stall_fd, valid_e, mem_read_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [11:0] ctrl_e;
  logic [15:0] stall_cnt;

  logic        stall_fd2, valid_e2, mem_read_e2;
  logic [31:0] rd1_e2, rd2_e2, imm_e2, pc_e2, pc_plus4_e2;
  logic [4:0]  rs1_e2, rs2_e2, rd_e2;
  logic [11:0] ctrl_e2;
  logic [1:0]  stall_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage_hz u_dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .imm_d(imm_d), .ctrl_d(ctrl_d), .mem_read_d(mem_read_d),
    .flush_e(flush_e), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .stall_fd(stall_fd), .valid_e(valid_e), .mem_read_e(mem_read_e), .rd1_e(rd1_e),
    .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .ctrl_e(ctrl_e), .stall_cnt(stall_cnt));

  decode_stage_hz #(.NREG(16), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .imm_d(imm_d), .ctrl_d(ctrl_d), .mem_read_d(mem_read_d),
    .flush_e(flush_e), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .stall_fd(stall_fd2), .valid_e(valid_e2), .mem_read_e(mem_read_e2), .rd1_e(rd1_e2),
    .rd2_e(rd2_e2), .imm_e(imm_e2), .pc_e(pc_e2), .pc_plus4_e(pc_plus4_e2), .rs1_e(rs1_e2),
    .rs2_e(rs2_e2), .rd_e(rd_e2), .ctrl_e(ctrl_e2), .stall_cnt(stall_cnt2));

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [31:0] ins, input logic ld,
                     input logic [11:0] c);
    valid_d    = v;
    instr_d    = ins;
    mem_read_d = ld;
    ctrl_d     = c;
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] val);
    reg_write_w = we;
    rd_w        = r;
    result_w    = val;
  endtask

  // Load into rd, then a dependent add: one stall edge, then capture.
  task automatic load_use(input logic [4:0] rd);
    dec(1'b1, mk(5'd2, 5'd0, rd), 1'b1, 12'h001);
    tick();
    dec(1'b1, mk(rd, 5'd1, rd + 5'd1), 1'b0, 12'h002);
    #1;
    chk("lu_stall", stall_fd, 1);
    tick();
    chk("lu_bubble", valid_e, 0);
    tick();
    chk("lu_capture", valid_e, 1);
  endtask

  initial begin
    rst = 1'b1;
    flush_e = 1'b0;
    pc_d = '0; pc_plus4_d = '0; imm_d = '0;
    dec(1'b0, 32'd0, 1'b0, 12'h000);
    wb(1'b0, 5'd0, 32'd0);
    #3;
    chk("rst_valid_e", valid_e, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_rd1_e", rd1_e, 0);
    tick();
    rst = 1'b0;

    // Write x5, first edge after reset with valid_d=0 loads a bubble.
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("bubble_no_valid", valid_e, 0);

    // add x6,x5,x0
    wb(1'b0, 5'd0, 32'd0);
    pc_d = 32'h100; pc_plus4_d = 32'h104; imm_d = 32'h7;
    dec(1'b1, mk(5'd5, 5'd0, 5'd6), 1'b0, 12'hABC);
    tick();
    chk("wr_rd1", rd1_e, 32'hDEADBEEF);
    chk("wr_rd2", rd2_e, 0);
    chk("wr_valid", valid_e, 1);
    chk("wr_rd", rd_e, 6);
    chk("wr_rs1", rs1_e, 5);
    chk("wr_pc", pc_e, 32'h100);
    chk("wr_pc4", pc_plus4_e, 32'h104);
    chk("wr_imm", imm_e, 7);
    chk("wr_ctrl", ctrl_e, 12'hABC);
    chk("wr_memrd", mem_read_e, 0);

    // lw x7 while writing x1=0x11, then add x8,x7,x1
    wb(1'b1, 5'd1, 32'h11);
    dec(1'b1, mk(5'd2, 5'd0, 5'd7), 1'b1, 12'h0F0);
    tick();
    chk("lw_valid", valid_e, 1);
    chk("lw_memrd", mem_read_e, 1);
    chk("lw_rd", rd_e, 7);
    wb(1'b0, 5'd0, 32'd0);
    dec(1'b1, mk(5'd7, 5'd1, 5'd8), 1'b0, 12'h00F);
    #1;
    chk("lu_stall_fd", stall_fd, 1);
    tick();
    chk("lu_valid0", valid_e, 0);
    chk("lu_memrd0", mem_read_e, 0);
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_stall_clear", stall_fd, 0);
    tick();
    chk("lu_valid1", valid_e, 1);
    chk("lu_rs1", rs1_e, 7);
    chk("lu_rs2", rs2_e, 1);
    chk("lu_rd8", rd_e, 8);
    chk("lu_rd2_x1", rd2_e, 32'h11);
    chk("lu_cnt_hold", stall_cnt, 1);

    // Flush beats hazard
    dec(1'b1, mk(5'd0, 5'd0, 5'd9), 1'b1, 12'h5A5);
    tick();
    dec(1'b1, mk(5'd9, 5'd9, 5'd10), 1'b0, 12'h123);
    flush_e = 1'b1;
    #1;
    chk("fl_stall_fd", stall_fd, 0);
    tick();
    flush_e = 1'b0;
    chk("fl_valid", valid_e, 0);
    chk("fl_ctrl", ctrl_e, 0);
    chk("fl_cnt", stall_cnt, 1);

    // Same-cycle bypass of x3
    wb(1'b1, 5'd3, 32'h55);
    dec(1'b1, mk(5'd3, 5'd3, 5'd4), 1'b0, 12'h001);
    tick();
    chk("byp_rd1", rd1_e, 32'h55);
    chk("byp_rd2", rd2_e, 32'h55);
    // Write to x0 is ignored, also on the same-cycle path
    wb(1'b1, 5'd0, 32'h1);
    dec(1'b1, mk(5'd0, 5'd0, 5'd11), 1'b0, 12'h001);
    tick();
    chk("x0_same_cycle", rd1_e, 0);
    wb(1'b0, 5'd0, 32'd0);
    dec(1'b1, mk(5'd0, 5'd3, 5'd12), 1'b0, 12'h001);
    tick();
    chk("x0_later", rd1_e, 0);
    chk("x3_stored", rd2_e, 32'h55);

    // Index 20: legal for NREG=32, ignored for NREG=16
    wb(1'b1, 5'd20, 32'h77);
    dec(1'b0, 32'd0, 1'b0, 12'h000);
    tick();
    wb(1'b1, 5'd20, 32'h99);
    dec(1'b1, mk(5'd20, 5'd5, 5'd13), 1'b0, 12'h001);
    tick();
    chk("n32_byp20", rd1_e, 32'h99);
    chk("n16_byp20", rd1_e2, 0);
    chk("n16_rs1_raw", rs1_e2, 20);
    chk("n16_rd2_x5", rd2_e2, 32'hDEADBEEF);
    wb(1'b0, 5'd0, 32'd0);
    dec(1'b1, mk(5'd20, 5'd0, 5'd14), 1'b0, 12'h001);
    tick();
    chk("n32_rd20", rd1_e, 32'h99);
    chk("n16_rd20", rd1_e2, 0);

    // Load to x0 never stalls
    dec(1'b1, mk(5'd2, 5'd0, 5'd0), 1'b1, 12'h001);
    tick();
    chk("ld0_memrd", mem_read_e, 1);
    dec(1'b1, mk(5'd0, 5'd0, 5'd15), 1'b0, 12'h001);
    #1;
    chk("ld0_nostall", stall_fd, 0);
    chk("ld0_nostall2", stall_fd2, 0);
    tick();
    chk("ld0_valid", valid_e, 1);

    // Saturation of the 2-bit counter (u_dut2 starts at 1)
    load_use(5'd7);
    load_use(5'd16);
    chk("sat_reach", stall_cnt2, 3);
    load_use(5'd21);
    load_use(5'd25);
    chk("sat_hold", stall_cnt2, 3);
    chk("cnt16_5", stall_cnt, 5);

    // Reset asserted mid-stall
    dec(1'b1, mk(5'd2, 5'd0, 5'd7), 1'b1, 12'h0AA);
    tick();
    dec(1'b1, mk(5'd7, 5'd1, 5'd8), 1'b0, 12'h0BB);
    #1;
    chk("pre_rst_stall", stall_fd, 1);
    chk("pre_rst_valid", valid_e, 1);
    chk("pre_rst_cnt2", stall_cnt2, 3);
    rst = 1'b1;
    #1;
    chk("arst_valid", valid_e, 0);
    chk("arst_memrd", mem_read_e, 0);
    chk("arst_ctrl", ctrl_e, 0);
    chk("arst_pc", pc_e, 0);
    chk("arst_rd", rd_e, 0);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_cnt2", stall_cnt2, 0);
    chk("arst_stall", stall_fd, 0);
    tick();
    rst = 1'b0;
    // First edge after reset captures the held decode; x1 was cleared
    tick();
    chk("post_rst_valid", valid_e, 1);
    chk("post_rst_rd2", rd2_e, 0);
    chk("post_rst_rd", rd_e, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
